nerv_wb_queue: RTL and testbench

Writeback stage directly upstream of the nerv_regs write port; it drives next_wr/wr_rd/next_rd.
- Accepts results from two producers: the single-cycle ALU path and the variable-latency load path.
- Arbitrates between them, buffers results in a small in-order queue, and drains one register write per cycle.
- Offers a youngest-match forwarding lookup so operand fetch can see values not yet committed to the register file.

---
 rtl/nerv_wb_pkg.sv | 13 +
 rtl/nerv_wb_fifo.sv | 71 +++++++
 rtl/nerv_wb_queue.sv | 113 +++++++++++
 tb/tb_nerv_wb_queue.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nerv_wb_pkg.sv
// rtl/nerv_wb_pkg.sv - shared types and defaults for the nerv writeback queue
package nerv_wb_pkg;

  localparam int WB_AW    = 5;
  localparam int WB_XLEN  = 32;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [WB_AW-1:0]   rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/nerv_wb_fifo.sv
// rtl/nerv_wb_fifo.sv - ring buffer with per-slot valid bits exposed for searching
module nerv_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [W-1:0]                push_data,
  input  logic                        pop,
  output logic [W-1:0]                pop_data,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0][W-1:0]     entries,
  output logic [DEPTH-1:0]            valid,
  output logic [$clog2(DEPTH)-1:0]    head_ptr
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW:0]             cnt;
  logic [DEPTH-1:0][W-1:0] mem;
  logic [DEPTH-1:0]        vld;
  logic                    do_push;
  logic                    do_pop;

  // Protect the pointers: a push into a full ring or a pop from an empty one is ignored.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full     = (cnt == (PW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign entries  = mem;
  assign valid    = vld;
  assign head_ptr = rd_ptr;

  // Pointer, occupancy and valid-bit bookkeeping; the pop clear is ordered before the push set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
    end else begin
      if (do_pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      if (do_push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage needs no reset; the valid bits decide what is meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nerv_wb_queue.sv
// rtl/nerv_wb_queue.sv - writeback arbiter/queue with forwarding lookup (NERV_WB_FWD_EN)
module nerv_wb_queue
  import nerv_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = WB_XLEN,
  parameter int AW    = WB_AW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [AW-1:0]            mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  input  logic                     wb_hold,
  output logic                     next_wr,
  output logic [AW-1:0]            wr_rd,
  output logic [XLEN-1:0]          next_rd,
  input  logic [AW-1:0]            fwd_addr1,
  input  logic [AW-1:0]            fwd_addr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [XLEN-1:0]          fwd_data1,
  output logic [XLEN-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = AW + XLEN;

  logic                     mem_fire;
  logic                     alu_fire;
  logic [AW-1:0]            sel_rd;
  logic [XLEN-1:0]          sel_data;
  logic                     push;
  logic [EW-1:0]            head;
  logic [DEPTH-1:0][EW-1:0] entries;
  logic [DEPTH-1:0]         valid;
  logic [PW-1:0]            head_ptr;

  // Load results win; the ALU only gets the slot when no load is offered.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign mem_fire  = mem_valid && mem_ready;
  assign alu_fire  = alu_valid && alu_ready;
  assign sel_rd    = mem_fire ? mem_rd : alu_rd;
  assign sel_data  = mem_fire ? mem_data : alu_data;

  // Writes to x0 are acknowledged but never stored.
  assign push = (mem_fire || alu_fire) && (sel_rd != AW'(REG_ZERO));

  // Drain strictly from registered queue state so producer inputs never reach the write port.
  assign next_wr = !empty && !wb_hold;
  assign wr_rd   = empty ? '0 : head[EW-1:XLEN];
  assign next_rd = empty ? '0 : head[XLEN-1:0];

  nerv_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({sel_rd, sel_data}),
    .pop       (next_wr),
    .pop_data  (head),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .entries   (entries),
    .valid     (valid),
    .head_ptr  (head_ptr)
  );

`ifdef NERV_WB_FWD_EN
  logic [PW-1:0] idx;

  // Walk oldest to youngest from the head so the last match seen is the youngest write.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_ptr + PW'(k);
      if (valid[idx] && fwd_addr1 != AW'(REG_ZERO) && entries[idx][EW-1:XLEN] == fwd_addr1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = entries[idx][XLEN-1:0];
      end
      if (valid[idx] && fwd_addr2 != AW'(REG_ZERO) && entries[idx][EW-1:XLEN] == fwd_addr2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = entries[idx][XLEN-1:0];
      end
    end
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{entries, valid, head_ptr, fwd_addr1, fwd_addr2};
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data1  = '0;
  assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_nerv_wb_queue.sv
// tb/tb_nerv_wb_queue.sv - self-checking bench for nerv_wb_queue
module tb_nerv_wb_queue;
  import nerv_wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, wb_hold;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd, fwd_addr1, fwd_addr2, wr_rd;
  logic [31:0] alu_data, mem_data, next_rd, fwd_data1, fwd_data2;
  logic        next_wr, fwd_hit1, fwd_hit2, full, empty;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  wb_entry_t q[$];

  nerv_wb_queue #(.DEPTH(DEPTH), .XLEN(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_hold(wb_hold), .next_wr(next_wr), .wr_rd(wr_rd), .next_rd(next_rd),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    alu_valid = 0; mem_valid = 0; wb_hold = 0;
    alu_rd = 0; mem_rd = 0; alu_data = 0; mem_data = 0;
    fwd_addr1 = 0; fwd_addr2 = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  // Reference model: a list of pending writes; the accept/drain rules are applied at each rising edge.
  task automatic advance();
    bit mem_acc, alu_acc, pop;
    wb_entry_t e;
    mem_acc = mem_valid && (q.size() < DEPTH);
    alu_acc = alu_valid && (q.size() < DEPTH) && !mem_valid;
    pop     = (q.size() > 0) && !wb_hold;
    e.rd    = mem_acc ? mem_rd : alu_rd;
    e.data  = mem_acc ? mem_data : alu_data;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if ((mem_acc || alu_acc) && e.rd != 0) q.push_back(e);
    @(negedge clk);
  endtask

  function automatic void model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] data);
    hit = 0;
    data = 0;
`ifdef NERV_WB_FWD_EN
    if (a != 0)
      foreach (q[i])
        if (q[i].rd == a) begin
          hit = 1;
          data = q[i].data;
        end
`endif
  endfunction

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    fwd_addr1 = 5'd7;
    fwd_addr2 = 5'd3;
    q.delete();
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (next_wr !== 1'b0) begin errors++; $display("FAIL reset_next_wr: got %b want 0", next_wr); end
    checks++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit: got %b%b want 00", fwd_hit1, fwd_hit2); end
    do_reset();
  endtask

  task automatic test_alu_single();
    do_reset();
    alu_valid = 1; alu_rd = 5; alu_data = 32'h11;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready_idle: got %b want 1", alu_ready); end
    advance();
    alu_valid = 0;
    #1;
    checks++; if (next_wr !== 1'b1) begin errors++; $display("FAIL alu_next_wr: got %b want 1", next_wr); end
    checks++; if (wr_rd !== 5'd5) begin errors++; $display("FAIL alu_wr_rd: got %0d want 5", wr_rd); end
    checks++; if (next_rd !== 32'h11) begin errors++; $display("FAIL alu_next_rd: got %h want 11", next_rd); end
    advance();
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL alu_empty_after: got %b want 1", empty); end
  endtask

  task automatic test_priority();
    do_reset();
    mem_valid = 1; mem_rd = 3; mem_data = 32'hAA;
    alu_valid = 1; alu_rd = 4; alu_data = 32'hBB;
    #1;
    checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin errors++; $display("FAIL prio_ready: got mem=%b alu=%b want mem=1 alu=0", mem_ready, alu_ready); end
    advance();
    mem_valid = 0;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL prio_alu_ready2: got %b want 1", alu_ready); end
    checks++; if (next_wr !== 1'b1 || wr_rd !== 5'd3 || next_rd !== 32'hAA) begin errors++; $display("FAIL prio_first_write: got wr=%b rd=%0d data=%h want 1/3/aa", next_wr, wr_rd, next_rd); end
    advance();
    alu_valid = 0;
    #1;
    checks++; if (next_wr !== 1'b1 || wr_rd !== 5'd4 || next_rd !== 32'hBB) begin errors++; $display("FAIL prio_second_write: got wr=%b rd=%0d data=%h want 1/4/bb", next_wr, wr_rd, next_rd); end
    advance();
  endtask

  task automatic test_hold_fill();
    do_reset();
    wb_hold = 1;
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1; alu_rd = 5'(i); alu_data = 32'h100 + 32'(i);
      advance();
    end
    alu_rd = 9; alu_data = 32'hDEAD;
    #1;
    checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL hold_full: got full=%b count=%0d want 1/4", full, count); end
    checks++; if (mem_ready !== 1'b0 || alu_ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got mem=%b alu=%b want 0/0", mem_ready, alu_ready); end
    checks++; if (next_wr !== 1'b0) begin errors++; $display("FAIL hold_next_wr: got %b want 0", next_wr); end
    advance();
    alu_valid = 0;
    wb_hold = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if (next_wr !== 1'b1 || wr_rd !== 5'(i) || next_rd !== 32'h100 + 32'(i)) begin errors++; $display("FAIL drain_%0d: got wr=%b rd=%0d data=%h want 1/%0d/%h", i, next_wr, wr_rd, next_rd, i, 32'h100 + 32'(i)); end
      advance();
    end
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_forwarding();
    logic eh;
    logic [31:0] ed;
    do_reset();
    wb_hold = 1;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h1;
    advance();
    alu_rd = 7; alu_data = 32'h2;
    advance();
    alu_rd = 9; alu_data = 32'h99;
    fwd_addr1 = 7; fwd_addr2 = 0;
    #1;
    model_fwd(5'd7, eh, ed);
    checks++; if (fwd_hit1 !== eh || fwd_data1 !== ed) begin errors++; $display("FAIL fwd_youngest: got hit=%b data=%h want %b/%h", fwd_hit1, fwd_data1, eh, ed); end
    checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'h0) begin errors++; $display("FAIL fwd_x0: got hit=%b data=%h want 0/0", fwd_hit2, fwd_data2); end
    fwd_addr2 = 9;
    #1;
    checks++; if (fwd_hit2 !== 1'b0) begin errors++; $display("FAIL fwd_incoming: got %b want 0", fwd_hit2); end
    alu_valid = 0;
    wb_hold = 0;
    #1;
    model_fwd(5'd7, eh, ed);
    checks++; if (fwd_hit1 !== eh || fwd_data1 !== ed || next_wr !== 1'b1) begin errors++; $display("FAIL fwd_popping_head: got hit=%b data=%h wr=%b want %b/%h/1", fwd_hit1, fwd_data1, next_wr, eh, ed); end
    for (int i = 0; i < 4; i++) advance();
  endtask

  task automatic test_rd_zero();
    do_reset();
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %b want 1", alu_ready); end
    advance();
    alu_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (next_wr !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rd0_no_write: got wr=%b count=%0d want 0/0", next_wr, count); end
      advance();
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    wb_hold = 1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'hC0 + 32'(i);
      advance();
    end
    alu_valid = 0;
    wb_hold = 0;
    advance();
    #2;
    reset = 1;
    #1;
    checks++; if (next_wr !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL midreset: got wr=%b count=%0d empty=%b want 0/0/1", next_wr, count, empty); end
    q.delete();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (next_wr !== 1'b0) begin errors++; $display("FAIL midreset_stale_%0d: got wr=%b want 0", i, next_wr); end
      advance();
    end
  endtask

  task automatic test_random();
    logic eh1, eh2;
    logic [31:0] ed1, ed2;
    int n;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      mem_valid = ($urandom_range(0, 99) < 35);
      alu_valid = ($urandom_range(0, 99) < 60);
      mem_rd = 5'($urandom_range(0, 7));
      alu_rd = 5'($urandom_range(0, 7));
      mem_data = $urandom;
      alu_data = $urandom;
      wb_hold = ($urandom_range(0, 99) < 30);
      fwd_addr1 = 5'($urandom_range(0, 7));
      fwd_addr2 = 5'($urandom_range(0, 7));
      #1;
      n = q.size();
      model_fwd(fwd_addr1, eh1, ed1);
      model_fwd(fwd_addr2, eh2, ed2);
      checks++; if (count !== 3'(n)) begin errors++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, count, n); end
      checks++; if (full !== (n == DEPTH) || empty !== (n == 0)) begin errors++; $display("FAIL rnd_flags c=%0d: got full=%b empty=%b for %0d entries", c, full, empty, n); end
      checks++; if (mem_ready !== (n < DEPTH) || alu_ready !== ((n < DEPTH) && !mem_valid)) begin errors++; $display("FAIL rnd_ready c=%0d: got mem=%b alu=%b", c, mem_ready, alu_ready); end
      checks++; if (next_wr !== ((n > 0) && !wb_hold)) begin errors++; $display("FAIL rnd_next_wr c=%0d: got %b", c, next_wr); end
      if (n > 0) begin
        checks++; if (wr_rd !== q[0].rd || next_rd !== q[0].data) begin errors++; $display("FAIL rnd_head c=%0d: got %0d/%h want %0d/%h", c, wr_rd, next_rd, q[0].rd, q[0].data); end
      end
      checks++; if (fwd_hit1 !== eh1 || fwd_data1 !== ed1) begin errors++; $display("FAIL rnd_fwd1 c=%0d: got %b/%h want %b/%h", c, fwd_hit1, fwd_data1, eh1, ed1); end
      checks++; if (fwd_hit2 !== eh2 || fwd_data2 !== ed2) begin errors++; $display("FAIL rnd_fwd2 c=%0d: got %b/%h want %b/%h", c, fwd_hit2, fwd_data2, eh2, ed2); end
      advance();
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_alu_single();
    test_priority();
    test_hold_fill();
    test_forwarding();
    test_rd_zero();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
